// File: rtl/dram_lsu_pkg.sv
// Shared types and the access-legality check for the data-RAM load/store unit.
package dram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Size code 2'b11 has no enum member and is always rejected.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lane[0];
            SZ_W:    return lane != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_ctrl.sv
// Byte/half lane extraction with sign or zero extension, and sub-word store merge.
module lsu_lane_ctrl
    import dram_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        sel_b     = word[{lane, 3'b000} +: 8];
        sel_h     = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        merged    = wdata;
        case (size)
            SZ_B: begin
                load_data = {{24{sel_b[7] & ~is_unsigned}}, sel_b};
                merged    = word;
                merged[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                load_data = {{16{sel_h[15] & ~is_unsigned}}, sel_h};
                merged    = word;
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dram_lsu.sv
// Load/store initiator for the distributed data RAM; sub-word stores are
// read-modify-write because the RAM only has a whole-word write enable.
module dram_lsu
    import dram_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [31:0]           ram_rdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [31:0]           ram_di,
    output logic                  ram_we
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH+1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [31:0]           load_data;
    logic [31:0]           merged;

    lsu_lane_ctrl u_lane (
        .size        (size_q),
        .lane        (addr_q[1:0]),
        .is_unsigned (uns_q),
        .word        (ram_rdata),
        .wdata       (data_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (access_err(req_size, req_addr[1:0]))  state_d = RESP;
                    else if (req_we && req_size == SZ_W)      state_d = WRITE;
                    else                                      state_d = READ;
                end
            end
            READ:    state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        ram_we     = (state_q == WRITE);
        resp_valid = (state_q == RESP);
        ram_raddr  = addr_q[ADDR_WIDTH+1:2];
        ram_waddr  = addr_q[ADDR_WIDTH+1:2];
        ram_di     = data_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Request latch, registered RAM read (extracted or merged) and response.
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    addr_d = req_addr;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    data_d = req_wdata;
                    if (access_err(req_size, req_addr[1:0])) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    data_d = merged;
                end else begin
                    rdata_d = load_data;
                    err_d   = 1'b0;
                end
            end
            WRITE: begin
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            data_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_lsu.sv
// Directed bench for dram_lsu with a behavioural 16x32 RAM and a response queue.
module tb_dram_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  ram_raddr;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_waddr;
    logic [31:0] ram_di;
    logic        ram_we;

    logic [31:0] mem [16];
    logic [32:0] exp_q [$];
    int          tests;
    int          fails;
    int          wr_cnt;
    logic [3:0]  last_waddr;
    logic [31:0] last_di;

    dram_lsu #(.ADDR_WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .ram_waddr    (ram_waddr),
        .ram_di       (ram_di),
        .ram_we       (ram_we)
    );

    // Clock and RAM model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_di;
    end
    assign ram_rdata = mem[ram_raddr];

    always @(negedge clk) begin
        if (ram_we) begin
            wr_cnt     = wr_cnt + 1;
            last_waddr = ram_waddr;
            last_di    = ram_di;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Driver: issues one request, measures latency, pops and checks the response.
    task automatic do_req(input string tag, input logic we, input logic [5:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wd,
                          input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                          input int e_wr, input logic [3:0] e_waddr, input logic [31:0] e_di);
        int lat;
        logic [32:0] e;
        exp_q.push_back({e_err, e_rdata});
        wait_idle();
        wr_cnt       = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_write_count"}, 32'(wr_cnt), 32'(e_wr));
        if (resp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, resp_rdata, e[31:0]);
            check({tag, "_err"}, 32'(resp_err), 32'(e[32]));
        end
        if (e_wr > 0) begin
            check({tag, "_waddr"}, 32'(last_waddr), 32'(e_waddr));
            check({tag, "_di"}, last_di, e_di);
        end
    endtask

    initial begin
        logic [32:0] e;
        logic [31:0] d;
        int          w;
        tests = 0;
        fails = 0;
        wr_cnt = 0;
        last_waddr = '0;
        last_di = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        req_wdata = '0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_waddr", 32'(ram_waddr), 32'd0);
        check("rst_ram_raddr", 32'(ram_raddr), 32'd0);
        check("rst_ram_di", ram_di, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req("sw04", 1'b1, 6'h04, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 4'd1, 32'hDEADBEEF);
        do_req("lw04", 1'b0, 6'h04, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 4'd0, 32'h0);
        do_req("sb06", 1'b1, 6'h06, 2'b00, 1'b0, 32'h0000005A, 32'h0, 1'b0, 3, 1, 4'd1, 32'hDE5ABEEF);
        do_req("lbu06", 1'b0, 6'h06, 2'b00, 1'b1, 32'h0, 32'h0000005A, 1'b0, 2, 0, 4'd0, 32'h0);
        do_req("lb07", 1'b0, 6'h07, 2'b00, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 4'd0, 32'h0);
        do_req("sh0a", 1'b1, 6'h0A, 2'b01, 1'b0, 32'h00008001, 32'h0, 1'b0, 3, 1, 4'd2, 32'h80010000);
        do_req("lh0a", 1'b0, 6'h0A, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 2, 0, 4'd0, 32'h0);
        do_req("lhu0a", 1'b0, 6'h0A, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 2, 0, 4'd0, 32'h0);

        do_req("err_lw02", 1'b0, 6'h02, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 4'd0, 32'h0);
        do_req("err_sh03", 1'b1, 6'h03, 2'b01, 1'b0, 32'h1234, 32'h0, 1'b1, 1, 0, 4'd0, 32'h0);
        do_req("err_sz11", 1'b1, 6'h00, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 4'd0, 32'h0);
        check("err_mem0_untouched", mem[0], 32'h0);

        // Reset asserted during the READ cycle of a byte store
        do_req("sw0c", 1'b1, 6'h0C, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 2, 1, 4'd3, 32'h12345678);
        wait_idle();
        wr_cnt    = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 6'h0D;
        req_size  = 2'b00;
        req_wdata = 32'h000000FF;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_read_raddr", 32'(ram_raddr), 32'd3);
        rst = 1'b1;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clk);
        end
        check("abort_no_write", 32'(wr_cnt), 32'd0);
        check("abort_mem3", mem[3], 32'h12345678);
        do_req("lw0c", 1'b0, 6'h0C, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, 2, 0, 4'd0, 32'h0);

        // Back-to-back: valid held high across two requests
        do_req("sw3c", 1'b1, 6'h3C, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0, 2, 1, 4'd15, 32'h11223344);
        wait_idle();
        exp_q.push_back({1'b0, 32'h11223344});
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_addr     = 6'h3C;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        @(negedge clk);
        req_we    = 1'b1;
        req_addr  = 6'h3F;
        req_size  = 2'b00;
        req_wdata = 32'h000000A5;
        check("b2b_ready_low_read", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_low_resp", 32'(req_ready), 32'd0);
        check("b2b_a_resp_valid", 32'(resp_valid), 32'd1);
        if (resp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("b2b_a_rdata", resp_rdata, e[31:0]);
        end
        wr_cnt = 0;
        @(negedge clk);
        check("b2b_ready_idle", 32'(req_ready), 32'd1);
        exp_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_b_accepted", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b_b_ram_we", 32'(ram_we), 32'd1);
        check("b2b_b_waddr", 32'(ram_waddr), 32'd15);
        check("b2b_b_di", ram_di, 32'hA5223344);
        @(negedge clk);
        check("b2b_b_resp_valid", 32'(resp_valid), 32'd1);
        if (resp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("b2b_b_rdata", resp_rdata, e[31:0]);
            check("b2b_b_err", 32'(resp_err), 32'(e[32]));
        end
        check("b2b_b_write_count", 32'(wr_cnt), 32'd1);
        check("wrap_mem15", mem[15], 32'hA5223344);
        check("wrap_mem0", mem[0], 32'h0);
        check("wrap_mem14", mem[14], 32'h0);
        do_req("lb3f", 1'b0, 6'h3F, 2'b00, 1'b0, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 0, 4'd0, 32'h0);

        // Random words: store, then read back upper half and byte 1
        for (int i = 0; i < 4; i++) begin
            w = 5 + i;
            d = $urandom;
            do_req("rnd_sw", 1'b1, 6'(w * 4), 2'b10, 1'b0, d, 32'h0, 1'b0, 2, 1, 4'(w), d);
            do_req("rnd_lhu", 1'b0, 6'(w * 4 + 2), 2'b01, 1'b1, 32'h0, {16'h0, d[31:16]}, 1'b0, 2, 0, 4'd0, 32'h0);
            do_req("rnd_lb", 1'b0, 6'(w * 4 + 1), 2'b00, 1'b0, 32'h0, {{24{d[15]}}, d[15:8]}, 1'b0, 2, 0, 4'd0, 32'h0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
